// File: rtl/snn_config_sequencer.sv
// snn_config_sequencer: byte-serial config loader and run controller
// for the 24-8-2 delayed SNN (config bank, enable, delay_clk tick).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_data/in_valid/     command/data byte stream; a byte is taken
//   in_ready              on a rising edge with in_valid && in_ready
//   weights, delays       flat bank views (bytes 0..51, 52..155)
//   threshold, decay,     fields of param byte (addr 156)
//   refractory_period
//   enable                run_req while idle
//   delay_clk             1-cycle tick, period delay_div+1 (addr 157)
//   busy, err             non-idle flag, sticky protocol error
module snn_config_sequencer #(
  parameter int WEIGHT_BYTES = 52,
  parameter int DELAY_BYTES  = 104,
  parameter int NUM_REGS     = WEIGHT_BYTES + DELAY_BYTES + 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [8*WEIGHT_BYTES-1:0] weights,
  output logic [8*DELAY_BYTES-1:0]  delays,
  output logic [1:0]                threshold,
  output logic [1:0]                decay,
  output logic [1:0]                refractory_period,
  output logic                      enable,
  output logic                      delay_clk,
  output logic                      busy,
  output logic                      err
);

  localparam int PARAM_ADDR = WEIGHT_BYTES + DELAY_BYTES;
  localparam int DIV_ADDR   = PARAM_ADDR + 1;

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_RUN    = 8'h02;
  localparam logic [7:0] CMD_HALT   = 8'h03;
  localparam logic [7:0] CMD_CLRERR = 8'h04;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    COMMIT
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] bank [NUM_REGS];
  logic [7:0] addr_ptr;
  logic [7:0] count;
  logic       run_req;
  logic [7:0] div_cnt;
  logic [7:0] delay_div;
  logic       acc;
  logic       in_range;

  assign acc      = in_valid && in_ready;
  assign in_range = 32'(addr_ptr) < NUM_REGS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    unique case (state)
      IDLE: begin
        if (acc && in_data == CMD_WRITE)
          state_nxt = ADDR;
      end
      ADDR: begin
        if (acc) state_nxt = LEN;
      end
      LEN: begin
        if (acc) state_nxt = DATA;
      end
      DATA: begin
        if (acc && count == 8'd0)
          state_nxt = COMMIT;
      end
      COMMIT: begin
        in_ready  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_ptr <= '0;
      count    <= '0;
      run_req  <= 1'b0;
      err      <= 1'b0;
    end else if (acc) begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            in_data == CMD_WRITE:  ;
            in_data == CMD_RUN:    run_req <= 1'b1;
            in_data == CMD_HALT:   run_req <= 1'b0;
            in_data == CMD_CLRERR: err <= 1'b0;
            default:               err <= 1'b1;
          endcase
        end
        ADDR: addr_ptr <= in_data;
        LEN:  count    <= in_data;
        DATA: begin
          // 8-bit pointer wraps 255->0 so low addresses
          // are written again after a wrap.
          addr_ptr <= addr_ptr + 8'd1;
          if (!in_range)     err   <= 1'b1;
          if (count != 8'd0) count <= count - 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        bank[i] <= '0;
    end else if (acc && state == DATA && in_range) begin
      bank[addr_ptr] <= in_data;
    end
  end

  for (genvar k = 0; k < WEIGHT_BYTES; k++) begin : g_w
    assign weights[8*k +: 8] = bank[k];
  end

  for (genvar j = 0; j < DELAY_BYTES; j++) begin : g_d
    assign delays[8*j +: 8] = bank[WEIGHT_BYTES + j];
  end

  assign threshold         = bank[PARAM_ADDR][1:0];
  assign decay             = bank[PARAM_ADDR][3:2];
  assign refractory_period = bank[PARAM_ADDR][5:4];
  assign delay_div         = bank[DIV_ADDR];

  assign busy   = state != IDLE;
  assign enable = run_req && (state == IDLE);

  // Counter is held at 0 while disabled so each enable
  // restarts the tick phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      delay_clk <= 1'b0;
    end else if (!enable) begin
      div_cnt   <= '0;
      delay_clk <= 1'b0;
    end else if (div_cnt == delay_div) begin
      div_cnt   <= '0;
      delay_clk <= 1'b1;
    end else begin
      div_cnt   <= div_cnt + 8'd1;
      delay_clk <= 1'b0;
    end
  end

endmodule
